regfile_dump: RTL
=================

# regfile_dump

Debug read-out engine for the multicycle core's 32x32 register file. On request it sweeps a range of register indices through one register-file read port and streams each value, tagged with its index, over a valid/ready output channel toward the debug/trace logic. It is a read-only consumer of the register file. It never writes registers, and it shares a read port with the datapath only while the core is halted.

## Interface
- No parameters. Data width is fixed at 32 and index width at 5.
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Reset, asynchronous and active-low.
- start  in  1  Begin a dump. Sampled only in IDLE.
- first  in  5  First index of the dump. Sampled with start.
- last  in  5  Last index of the dump. Sampled with start.
- abort  in  1  Cancels the dump in progress. Synchronous.
- busy  out  1  High in any state other than IDLE.
- ra  out  5  Register-file read address. The register file returns read data combinationally, in the same cycle.
- rd  in  32  Register-file read data. Index 0 always reads 0.
- out_valid  out  1  A word is presented on the output channel.
- out_ready  in  1  The consumer accepts the presented word.
- out_data  out  32  Register value.
- out_idx  out  5  Index of the register in out_data.
- out_last  out  1  Marks the final word of the dump.
- done  out  1  One-cycle pulse after the final word is accepted.

## Operation
- States:
  - IDLE: waits for start.
  - READ: drives ra, captures rd.
  - SEND: presents the captured word.
  - FIN: pulses done.
- IDLE:
  - ra=0, out_valid=0.
  - start=1 latches first and last into cur and end, then goes to READ.
- READ:
  - ra=cur.
  - At the clock edge, out_data<=rd, out_idx<=cur, out_last<=(cur==end), then go to SEND.
- SEND:
  - out_valid=1. out_data, out_idx and out_last are held stable until the word is accepted.
  - out_valid&out_ready: if out_last, go to FIN; otherwise cur<=cur+1 (mod 32) and go to READ.
  - out_valid stays high while out_ready=0, with no timeout.
- FIN: done=1 for one cycle, then go to IDLE.
- Range and wrap rules:
  - The index arithmetic is 5-bit and wraps 31->0.
  - Word count = ((last-first) mod 32)+1.
  - first==last gives 1 word.
  - first=last+1 (mod 32) gives all 32 registers.
- Snapshot: each word reflects the register-file contents in the READ cycle of that word. A write in the same cycle is not visible; it is picked up only if the register is read later.
- Simultaneous events and boundary cases:
  - start while busy: ignored, and first/last are not resampled.
  - abort in any non-IDLE state: next state is IDLE, out_valid drops at the next edge, and no done pulse is produced.
  - abort together with a completing handshake in SEND: the transfer counts, but the next state is still IDLE and no done pulse is produced.
  - start and abort together in IDLE: abort wins and the engine stays in IDLE.
- Reset (asserted at any time, including mid-dump):
  - Immediately: state=IDLE, busy=0, ra=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0.
  - No partial dump resumes after reset.

## Timing
- start sampled at edge E0: READ with ra=first in cycle E0..E1, then out_valid=1 from E1.
- With out_ready tied high:
  - One word is produced every 2 cycles.
  - An N-word dump has busy high for 2N+1 cycles, counted from E0 through the done cycle.
- The done pulse occurs in the cycle after the edge that accepts out_last. busy is still 1 in that cycle and falls at the next edge.
- out_valid never depends combinationally on out_ready.
- ra depends only on state and cur, both registered, so no combinational path exists from any input to ra.

## Test plan
- Register file preloaded with regs[i]=0x100+i, start with first=3, last=5, out_ready=1:
  - Words (3,0x103), (5,0x105) and the one between them appear, out_last only on idx 5.
  - done pulses once.
  - busy is high for exactly 7 cycles.
- first=0, last=0:
  - Single word (0, 0x00000000) with out_last=1, even though the backing storage for index 0 holds a nonzero value.
- Wrap test with first=30, last=1:
  - Indices 30, 31, 0, 1 in order, 4 words.
  - first=5, last=4 yields all 32 words, ending at idx 4.
- Backpressure: out_ready low for 5 cycles on the second word:
  - out_valid stays high and out_data/out_idx stay stable for all 5 cycles.
  - No word is skipped or duplicated.
- abort in the SEND of word 2 of a 4-word dump:
  - IDLE at the next edge, out_valid=0, no done pulse.
  - A following start works normally.
  - start pulsed during a dump has no effect.
- rst_n asserted mid-SEND:
  - All outputs go to 0 asynchronously, before the next clock edge.
  - After release, the engine is in IDLE and waits for start.

Source files
------------

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - Sweeps a register-file index range through one read port and streams tagged words.
module regfile_dump (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  first,
    input  logic [4:0]  last,
    input  logic        abort,
    output logic        busy,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cur;
    logic [4:0]  cur_nx;
    logic [4:0]  end_idx;
    logic [4:0]  end_nx;
    logic        capture;

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        end_nx   = end_idx;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    cur_nx   = first;
                    end_nx   = last;
                    state_nx = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    capture  = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                // An accepted word under abort still counts, but the dump ends here.
                if (abort) begin
                    state_nx = IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_nx = FIN;
                    end else begin
                        cur_nx   = cur + 5'd1;
                        state_nx = READ;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= 5'd0;
            end_idx  <= 5'd0;
            out_data <= 32'd0;
            out_idx  <= 5'd0;
            out_last <= 1'b0;
        end else begin
            state   <= state_nx;
            cur     <= cur_nx;
            end_idx <= end_nx;
            if (capture) begin
                // Index 0 is architecturally zero whatever the storage behind it holds.
                out_data <= (cur == 5'd0) ? 32'd0 : rd;
                out_idx  <= cur;
                out_last <= (cur == end_idx);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign ra        = (state == READ) ? cur : 5'd0;
    assign out_valid = (state == SEND);
    assign done      = (state == FIN) && !abort;

endmodule
